rom_line_cache: RTL and testbench

- Upstream client of spi_mem on the sample-ROM read path.
- Accepts single-byte read requests from the YM2610 ADPCM address decoder.
- Serves requests from two 32-bit line buffers, one per SPI device select (0 = flash, 1 = PSRAM).
- On a miss, issues 4-byte aligned reads on the spi_mem mem_* interface.

---
 rtl/rom_line_cache_if.sv | 32 +++
 rtl/rom_line_cache.sv | 167 ++++++++++++++++
 tb/tb_rom_line_cache.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_line_cache_if.sv
// Bus bundle for rom_line_cache: client byte-request port and spi_mem line-fetch port.
// The slave modport is the cache; the master modport is its environment (client + spi_mem).
interface rom_line_cache_if #(
    parameter int ADDR_W = 24
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_select;
    logic              req_ready;
    logic [7:0]        req_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic              mem_we;
    logic              mem_select;
    logic [1:0]        mem_length;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport slave (
        input  req_valid, req_addr, req_select, mem_rdata, mem_ready,
        output req_ready, req_rdata, mem_addr, mem_valid, mem_we, mem_select,
               mem_length, mem_wdata
    );

    modport master (
        output req_valid, req_addr, req_select, mem_rdata, mem_ready,
        input  req_ready, req_rdata, mem_addr, mem_valid, mem_we, mem_select,
               mem_length, mem_wdata
    );
endinterface

// File: rtl/rom_line_cache.sv
// Two-line (flash / PSRAM) byte read cache in front of spi_mem on the sample-ROM path.
// Optional hit/miss counters are enabled by defining ROM_LINE_CACHE_STATS_EN.
module rom_line_cache #(
    parameter int         ADDR_W   = 24,
    parameter logic [1:0] LINE_LEN = 2'd3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    rom_line_cache_if.slave       bus
`ifdef ROM_LINE_CACHE_STATS_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);
    localparam int TAG_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_valid;
    logic [TAG_W-1:0]  r_tag [2];
    logic [31:0]       r_data [2];
    logic              r_flush_seen;
    logic              r_req_ready;
    logic [7:0]        r_req_rdata;
    logic              r_mem_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_select;

    logic              w_hit;
    logic              w_hit_rsp;
    logic              w_fill;

    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    // Hit detection; a flush in the same cycle forces the request down the miss path.
    always_comb begin
        w_hit     = r_valid[bus.req_select]
                    && (r_tag[bus.req_select] == bus.req_addr[ADDR_W-1:2])
                    && !flush;
        w_hit_rsp = (r_state == S_IDLE) && bus.req_valid && w_hit;
        w_fill    = (r_state == S_FETCH) && bus.mem_ready;
    end

    // Request/fetch state machine with the line storage and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_valid      <= 2'b00;
            r_tag[0]     <= '0;
            r_tag[1]     <= '0;
            r_data[0]    <= 32'd0;
            r_data[1]    <= 32'd0;
            r_flush_seen <= 1'b0;
            r_req_ready  <= 1'b0;
            r_req_rdata  <= 8'd0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_select <= 1'b0;
        end else begin
            r_req_ready <= 1'b0;
            if (flush) begin
                r_valid <= 2'b00;
            end else begin
                r_valid <= r_valid;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_hit_rsp) begin
                        r_req_ready <= 1'b1;
                        r_req_rdata <= byte_of(r_data[bus.req_select], bus.req_addr[1:0]);
                        r_state     <= S_HOLD;
                    end else if (bus.req_valid) begin
                        r_mem_valid  <= 1'b1;
                        r_mem_addr   <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                        r_mem_select <= bus.req_select;
                        r_flush_seen <= 1'b0;
                        r_state      <= S_FETCH;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    if (w_fill) begin
                        r_mem_valid                <= 1'b0;
                        r_data[r_mem_select]       <= bus.mem_rdata;
                        r_tag[r_mem_select]        <= r_mem_addr[ADDR_W-1:2];
                        // A flush anywhere in the fetch leaves the freshly filled line invalid.
                        r_valid[r_mem_select]      <= !(r_flush_seen || flush);
                        if (bus.req_valid) begin
                            r_req_ready <= 1'b1;
                            r_req_rdata <= byte_of(bus.mem_rdata, bus.req_addr[1:0]);
                            r_state     <= S_HOLD;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (flush) begin
                        r_flush_seen <= 1'b1;
                    end else begin
                        r_flush_seen <= r_flush_seen;
                    end
                end
                S_HOLD: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_mem_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.req_rdata  = r_req_rdata;
    assign bus.mem_valid  = r_mem_valid;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_select = r_mem_select;
    assign bus.mem_we     = 1'b0;
    assign bus.mem_length = LINE_LEN;
    assign bus.mem_wdata  = 32'd0;

`ifdef ROM_LINE_CACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    // Saturating hit/miss counters, cleared together with the lines on flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_count  <= 16'd0;
            r_miss_count <= 16'd0;
        end else if (flush) begin
            r_hit_count  <= 16'd0;
            r_miss_count <= 16'd0;
        end else begin
            if (w_hit_rsp && (r_hit_count != 16'hFFFF)) begin
                r_hit_count <= r_hit_count + 16'd1;
            end else begin
                r_hit_count <= r_hit_count;
            end
            if (w_fill && (r_miss_count != 16'hFFFF)) begin
                r_miss_count <= r_miss_count + 16'd1;
            end else begin
                r_miss_count <= r_miss_count;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif
endmodule

// File: tb/tb_rom_line_cache.sv
// Randomized self-checking bench for rom_line_cache with a spi_mem responder and a line-level model.
// Builds with or without ROM_LINE_CACHE_STATS_EN.
module tb_rom_line_cache;
    logic clk;
    logic reset;
    logic flush;

    rom_line_cache_if #(.ADDR_W(24)) bus ();

`ifdef ROM_LINE_CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    rom_line_cache #(.ADDR_W(24), .LINE_LEN(2'd3)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
`ifdef ROM_LINE_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int passed;
    int fetches;
    int mem_lat;

    // Reference model: which line each select currently holds.
    bit          mv [2];
    logic [21:0] mtag [2];

    // Results of the most recent request.
    bit          g_got;
    logic [7:0]  g_data;
    int          g_lat;
    int          g_fetched;
    logic        g_first_mv;
    logic [23:0] g_first_addr;
    logic [1:0]  g_first_len;
    logic        g_first_we;
    logic [31:0] g_first_wd;
    logic        g_mv_at_ready;

    function automatic logic [31:0] rom_word(input logic sel, input logic [23:0] a);
        if (a == 24'h000104) return sel ? 32'hDDCCBBAA : 32'h44332211;
        return ({8'd0, a} * 32'h9E3779B1) ^ (sel ? 32'hA5A5A5A5 : 32'h3C3C3C3C);
    endfunction

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] k);
        logic [31:0] s;
        s = w >> (8 * int'(k));
        return s[7:0];
    endfunction

    task automatic model_flush();
        mv[0] = 1'b0;
        mv[1] = 1'b0;
    endtask

    // spi_mem stand-in: completes a fetch mem_lat cycles after mem_valid rises.
    initial begin : mem_model
        int          cnt;
        logic [23:0] cur_a;
        logic        cur_s;
        cnt = 0;
        cur_a = 24'd0;
        cur_s = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (reset || !bus.mem_valid) begin
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    cur_a = bus.mem_addr;
                    cur_s = bus.mem_select;
                end else begin
                    total++;
                    if (bus.mem_addr !== cur_a || bus.mem_select !== cur_s)
                        $display("FAIL mem_stable: got %h/%b required %h/%b", bus.mem_addr, bus.mem_select, cur_a, cur_s);
                    else passed++;
                end
                cnt++;
                if (cnt >= mem_lat) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = rom_word(cur_s, cur_a);
                    cnt = 0;
                    fetches++;
                end
            end
        end
    end

    task automatic issue(input logic sel, input logic [23:0] a, input int fl_at);
        int f0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr = a;
        bus.req_select = sel;
        flush = (fl_at == 0);
        f0 = fetches;
        g_got = 1'b0; g_data = 8'd0; g_lat = 0; g_mv_at_ready = 1'b1;
        g_first_mv = 1'b0; g_first_addr = 24'd0; g_first_len = 2'd0; g_first_we = 1'b1; g_first_wd = 32'd1;
        while (!g_got && g_lat < 300) begin
            @(posedge clk); #1;
            g_lat++;
            flush = (g_lat == fl_at);
            if (g_lat == 1) begin
                g_first_mv = bus.mem_valid;
                g_first_addr = bus.mem_addr;
                g_first_len = bus.mem_length;
                g_first_we = bus.mem_we;
                g_first_wd = bus.mem_wdata;
            end
            if (bus.req_ready) begin
                g_got = 1'b1;
                g_data = bus.req_rdata;
                g_mv_at_ready = bus.mem_valid;
            end
        end
        flush = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.req_ready !== 1'b0) $display("FAIL ready_pulse: got %b required 0", bus.req_ready);
        else passed++;
        g_fetched = fetches - f0;
    endtask

    task automatic req_check(input string nm, input logic sel, input logic [23:0] a, input int fl_at);
        bit         hit;
        int         exp_lat;
        logic [7:0] exp_b;
        if (fl_at == 0) model_flush();
        hit = mv[sel] && (mtag[sel] == a[23:2]);
        exp_lat = hit ? 1 : mem_lat + 1;
        exp_b = pick_byte(rom_word(sel, {a[23:2], 2'b00}), a[1:0]);
        issue(sel, a, fl_at);
        total++;
        if (g_got !== 1'b1 || g_data !== exp_b)
            $display("FAIL %s data: got ready=%b byte=%h required ready=1 byte=%h", nm, g_got, g_data, exp_b);
        else passed++;
        total++;
        if (g_fetched != (hit ? 0 : 1))
            $display("FAIL %s fetches: got %0d required %0d", nm, g_fetched, hit ? 0 : 1);
        else passed++;
        total++;
        if (g_lat != exp_lat) $display("FAIL %s latency: got %0d required %0d", nm, g_lat, exp_lat);
        else passed++;
        total++;
        if (g_mv_at_ready !== 1'b0) $display("FAIL %s mem_valid_at_ready: got %b required 0", nm, g_mv_at_ready);
        else passed++;
        if (fl_at >= 1 && fl_at < exp_lat) model_flush();
        if (!hit) begin
            mtag[sel] = a[23:2];
            mv[sel] = !(fl_at >= 1 && fl_at < exp_lat);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr = 24'd0;
        bus.req_select = 1'b0;
        model_flush();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.req_ready, bus.req_rdata, bus.mem_valid, bus.mem_addr, bus.mem_select} !== 35'd0)
            $display("FAIL reset_outputs: got %b/%h/%b/%h/%b required all zero",
                     bus.req_ready, bus.req_rdata, bus.mem_valid, bus.mem_addr, bus.mem_select);
        else passed++;
`ifdef ROM_LINE_CACHE_STATS_EN
        total++;
        if (hit_count !== 16'd0 || miss_count !== 16'd0)
            $display("FAIL reset_stats: got %0d/%0d required 0/0", hit_count, miss_count);
        else passed++;
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_cold_miss();
        mem_lat = 30;
        req_check("cold_miss", 1'b0, 24'h000105, -1);
        total++;
        if (g_data !== 8'h22) $display("FAIL cold_byte: got %h required 22", g_data);
        else passed++;
        total++;
        if (g_first_mv !== 1'b1 || g_first_addr !== 24'h000104)
            $display("FAIL cold_mem_req: got valid=%b addr=%h required valid=1 addr=000104", g_first_mv, g_first_addr);
        else passed++;
        total++;
        if (g_first_len !== 2'd3 || g_first_we !== 1'b0 || g_first_wd !== 32'd0)
            $display("FAIL cold_mem_consts: got len=%0d we=%b wdata=%h required 3/0/0", g_first_len, g_first_we, g_first_wd);
        else passed++;
    endtask

    task automatic test_hit();
        req_check("hit", 1'b0, 24'h000107, -1);
        total++;
        if (g_first_mv !== 1'b0 || g_data !== 8'h44)
            $display("FAIL hit_direct: got mem_valid=%b byte=%h required 0/44", g_first_mv, g_data);
        else passed++;
`ifdef ROM_LINE_CACHE_STATS_EN
        total++;
        if (hit_count !== 16'd1 || miss_count !== 16'd1)
            $display("FAIL stats: got hit=%0d miss=%0d required 1/1", hit_count, miss_count);
        else passed++;
`endif
    endtask

    task automatic test_back_to_back();
        int f0;
        f0 = fetches;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr = 24'h000106;
        bus.req_select = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            total++;
            if (bus.req_ready !== ((i % 2) == 1) || (bus.req_ready && bus.req_rdata !== 8'h33))
                $display("FAIL b2b_cycle%0d: got ready=%b byte=%h required ready=%b byte=33",
                         i, bus.req_ready, bus.req_rdata, (i % 2) == 1);
            else passed++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (fetches != f0) $display("FAIL b2b_fetches: got %0d required 0", fetches - f0);
        else passed++;
    endtask

    task automatic test_dual_lines();
        mem_lat = 5;
        req_check("dual_sel1", 1'b1, 24'h000104, -1);
        total++;
        if (g_fetched != 1 || g_data !== 8'hAA) $display("FAIL dual_sel1_direct: got %0d/%h required 1/aa", g_fetched, g_data);
        else passed++;
        req_check("dual_sel0", 1'b0, 24'h000104, -1);
        total++;
        if (g_fetched != 0 || g_data !== 8'h11) $display("FAIL dual_sel0_direct: got %0d/%h required 0/11", g_fetched, g_data);
        else passed++;
    endtask

    task automatic test_flush_fetch();
        mem_lat = 10;
        req_check("flush_fetch", 1'b0, 24'h000201, 4);
        req_check("flush_refetch", 1'b0, 24'h000203, -1);
        total++;
        if (g_fetched != 1) $display("FAIL flush_refetch_direct: got %0d required 1", g_fetched);
        else passed++;
    endtask

    task automatic test_flush_hit();
        mem_lat = 4;
        req_check("prefill", 1'b0, 24'h000104, -1);
        req_check("flush_hit", 1'b0, 24'h000107, 0);
        total++;
        if (g_first_mv !== 1'b1) $display("FAIL flush_hit_mem_valid: got %b required 1", g_first_mv);
        else passed++;
    endtask

    task automatic test_abandon();
        int f0;
        bit saw;
        mem_lat = 12;
        f0 = fetches;
        saw = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr = 24'h000300;
        bus.req_select = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.req_ready) saw = 1'b1;
        end
        total++;
        if (saw) $display("FAIL abandon_no_ready: got 1 required 0");
        else passed++;
        total++;
        if (fetches - f0 != 1) $display("FAIL abandon_fill: got %0d required 1", fetches - f0);
        else passed++;
        mtag[1] = 22'(24'h000300 >> 2);
        mv[1] = 1'b1;
        req_check("abandon_hit", 1'b1, 24'h000302, -1);
    endtask

    task automatic test_reset_mid_fetch();
        mem_lat = 20;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr = 24'h000400;
        bus.req_select = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (bus.mem_valid !== 1'b1) $display("FAIL rst_fetch_active: got %b required 1", bus.mem_valid);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (bus.mem_valid !== 1'b0) $display("FAIL rst_async_drop: got %b required 0", bus.mem_valid);
        else passed++;
        bus.req_valid = 1'b0;
        model_flush();
        @(negedge clk);
        reset = 1'b0;
        mem_lat = 3;
        req_check("after_rst_sel0", 1'b0, 24'h000105, -1);
        req_check("after_rst_sel1", 1'b1, 24'h000302, -1);
    endtask

    task automatic test_random();
        logic [23:0] pool [5];
        logic [23:0] a;
        logic        sel;
        int          fl;
        pool[0] = 24'h000104; pool[1] = 24'h000200; pool[2] = 24'hFFFFFC;
        pool[3] = 24'h010104; pool[4] = 24'h7FFFF0;
        for (int i = 0; i < 60; i++) begin
            mem_lat = $urandom_range(1, 6);
            sel = 1'($urandom_range(0, 1));
            a = pool[$urandom_range(0, 4)] | 24'($urandom_range(0, 3));
            fl = ($urandom_range(0, 7) == 0) ? 0 : -1;
            req_check("random", sel, a, fl);
        end
    endtask

    initial begin
        total = 0;
        passed = 0;
        fetches = 0;
        mem_lat = 1;
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_dual_lines();
        test_flush_fetch();
        test_flush_hit();
        test_abandon();
        test_reset_mid_fetch();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
